mem_port_responder: RTL and testbench

MEM_PORT_RESPONDER -- requirements
Module: mem_port_responder

---
 rtl/mem_port_responder.sv | 116 +++++++++++
 tb/tb_mem_port_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_responder.sv
// Single-port 16-bit memory behind a shared tri-state bus with strobe handshake and wait states.
// Optional macro MEM_WAIT_STATE_EN adds a WAIT state with a WAIT_CYCLES counter; without it accesses complete on acceptance.
module mem_port_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [15:0]       data,
  input  logic              mem_write,
  input  logic              mem_read,
  output logic              ready,
  output logic              busy
);

`ifdef MEM_WAIT_STATE_EN
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
`else
  typedef enum logic [1:0] {IDLE, ACCESS} state_t;
`endif

  state_t      state;
  logic        dir_out;
  logic [15:0] dout_q;
  logic [15:0] mem [0:2**ADDR_W-1];
  logic        mem_we;
  logic [ADDR_W-1:0] mem_waddr;

`ifdef MEM_WAIT_STATE_EN
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        cnt;
  logic              strobe_ok;

  // The latched strobe must still be the only one asserted; anything else aborts the wait.
  assign strobe_ok = dir_out ? (mem_write & ~mem_read) : (mem_read & ~mem_write);
  assign mem_we    = rst_n && (state == WAIT) && (cnt == 4'd0) && strobe_ok && !dir_out;
  assign mem_waddr = addr_q;
`else
  logic [3:0] unused_wait;

  assign unused_wait = 4'(WAIT_CYCLES);
  assign mem_we      = rst_n && (state == IDLE) && mem_read && !mem_write;
  assign mem_waddr   = addr;
`endif

  assign data = (state == ACCESS && dir_out && mem_write && !mem_read) ? dout_q : 16'hzzzz;

  // Memory contents survive reset; the write is simply suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b0;
      busy    <= 1'b0;
      dout_q  <= 16'h0000;
      dir_out <= 1'b0;
`ifdef MEM_WAIT_STATE_EN
      cnt     <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_write ^ mem_read) begin
            dir_out <= mem_write;
            busy    <= 1'b1;
`ifdef MEM_WAIT_STATE_EN
            addr_q  <= addr;
            cnt     <= CNT_INIT;
            state   <= WAIT;
`else
            if (mem_write)
              dout_q <= mem[addr];
            ready   <= 1'b1;
            state   <= ACCESS;
`endif
          end
        end
`ifdef MEM_WAIT_STATE_EN
        WAIT: begin
          if (!strobe_ok) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == 4'd0) begin
            if (dir_out)
              dout_q <= mem[addr_q];
            ready <= 1'b1;
            state <= ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`endif
        ACCESS: begin
          // Holding a strobe keeps the completed access; only full release returns to IDLE.
          if (!mem_write && !mem_read) begin
            state <= IDLE;
            ready <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder; expectations follow the MEM_WAIT_STATE_EN setting of the build.
module tb_mem_port_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_write;
  logic        mem_read;
  logic [7:0]  addr;
  wire  [15:0] data;
  logic        tb_en;
  logic [15:0] tb_dat;
  logic        ready;
  logic        busy;
  int          errors = 0;
  int          checks = 0;
  int          n;

`ifdef MEM_WAIT_STATE_EN
  localparam int ACC_EDGES = 3;
`else
  localparam int ACC_EDGES = 1;
`endif

  assign data = tb_en ? tb_dat : 16'hzzzz;

  always #5 clk = ~clk;

  mem_port_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .data      (data),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .ready     (ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, {15'd0, ready}, 16'd0);
    chk({tag, "_busy"},  {15'd0, busy},  16'd0);
    chk({tag, "_dataz"}, data, 16'hzzzz);
  endtask

  // Capture a word: core drives the bus with mem_read high.
  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    int k;
    addr = a; tb_dat = d; tb_en = 1'b1; mem_read = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ready && k < 20);
    chk("wr_latency", 16'(k), 16'(ACC_EDGES));
    chk("wr_busy", {15'd0, busy}, 16'd1);
    mem_read = 1'b0; tb_en = 1'b0;
    @(negedge clk);
    chk_idle("wr_release");
  endtask

  // Fetch a word: DUT drives the bus while mem_write is held.
  task automatic do_read(input logic [7:0] a, input logic [15:0] exp);
    int k;
    addr = a; mem_write = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!ready) chk("rd_wait_dataz", data, 16'hzzzz);
    end while (!ready && k < 20);
    chk("rd_latency", 16'(k), 16'(ACC_EDGES));
    chk("rd_data", data, exp);
    @(negedge clk);
    chk("rd_hold_ready", {15'd0, ready}, 16'd1);
    chk("rd_hold_data", data, exp);
    mem_write = 1'b0;
    @(negedge clk);
    chk_idle("rd_release");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    addr = 8'h00; tb_en = 1'b0; tb_dat = 16'h0000;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Capture BEEF at 0x12, moving addr right after acceptance.
    addr = 8'h12; tb_dat = 16'hBEEF; tb_en = 1'b1; mem_read = 1'b1;
    @(negedge clk);
    chk("cap_busy", {15'd0, busy}, 16'd1);
    addr = 8'h33;
    n = 1;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cap_latency", 16'(n), 16'(ACC_EDGES));
    mem_read = 1'b0; tb_en = 1'b0;
    @(negedge clk);
    chk_idle("cap_release");

    do_read(8'h12, 16'hBEEF);

    // Both strobes together are never accepted.
    mem_write = 1'b1; mem_read = 1'b1; addr = 8'h12;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle("both_strobes");
    end
    mem_write = 1'b0; mem_read = 1'b0;
    @(negedge clk);

    do_write(8'h05, 16'h5555);
    do_write(8'hA0, 16'h0F0F);

`ifdef MEM_WAIT_STATE_EN
    // Strobe dropped after one WAIT cycle.
    addr = 8'h05; tb_dat = 16'h1234; tb_en = 1'b1; mem_read = 1'b1;
    @(negedge clk);
    chk("abort_drop_busy_wait", {15'd0, busy}, 16'd1);
    mem_read = 1'b0; tb_en = 1'b0;
    @(negedge clk);
    chk_idle("abort_drop");
    @(negedge clk);
    chk_idle("abort_drop_after");

    // Second strobe raised during WAIT.
    addr = 8'hA0; tb_dat = 16'hFFFF; tb_en = 1'b1; mem_read = 1'b1;
    @(negedge clk);
    mem_write = 1'b1;
    @(negedge clk);
    chk("abort_both_busy", {15'd0, busy}, 16'd0);
    chk("abort_both_ready", {15'd0, ready}, 16'd0);
    mem_write = 1'b0; mem_read = 1'b0; tb_en = 1'b0;
    @(negedge clk);
`endif

    do_read(8'h05, 16'h5555);
    do_read(8'hA0, 16'h0F0F);

    // Reset while the DUT is driving the bus.
    addr = 8'h05; mem_write = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 20);
    chk("rstmid_data_before", data, 16'h5555);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle("rstmid");
    rst_n = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    chk_idle("rstmid_after");

    do_read(8'h12, 16'hBEEF);
    do_read(8'h05, 16'h5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
